button_event_arbiter: RTL

//  Debounces N_BTN raw push-buttons with one btn_debounce_cell per button.

---
 rtl/button_event_arbiter_pkg.sv | 7 +
 rtl/button_event_arbiter_debounce_cell.sv | 47 ++++
 rtl/button_event_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/button_event_arbiter_pkg.sv
// Shared constants for the button event arbiter: debounce default and counter width.
package button_event_arbiter_pkg;

   localparam int unsigned DebCyclesDefault = 500;
   localparam int unsigned BtnCntW          = 32;

endpackage

// File: rtl/button_event_arbiter_debounce_cell.sv
// Single-button debouncer: accepts a new level after a run of identical mismatching
// samples, and flags the first cycle of a debounced high level.
module button_event_arbiter_debounce_cell
   import button_event_arbiter_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = DebCyclesDefault
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic level_o,
   output logic rise_o
);

   logic [BtnCntW-1:0] cnt_q, cnt_d;
   logic               level_q, level_d;
   logic               level_prev_q;

   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      // Any sample that matches the current level (a bounce) restarts the count.
      if (btn_i != level_q) begin
         if (cnt_q == BtnCntW'(DEB_CYCLES)) begin
            level_d = btn_i;
         end else begin
            cnt_d = cnt_q + BtnCntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q        <= '0;
         level_q      <= 1'b0;
         level_prev_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         level_q      <= level_d;
         level_prev_q <= level_q;
      end
   end

   assign level_o = level_q;
   assign rise_o  = level_q & ~level_prev_q;

endmodule

// File: rtl/button_event_arbiter.sv
// Debounced buttons -> press events -> round-robin into a show-ahead event FIFO.
// Optional auto-repeat while held is enabled by defining BTN_REPEAT_EN.
module button_event_arbiter
   import button_event_arbiter_pkg::*;
#(
   parameter  int unsigned N_BTN      = 5,
   parameter  int unsigned DEB_CYCLES = DebCyclesDefault,
   parameter  int unsigned QDEPTH     = 4,
   parameter  int unsigned REP_DELAY  = 50000000,
   parameter  int unsigned REP_PERIOD = 10000000,
   localparam int unsigned IDW        = $clog2(N_BTN)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [N_BTN-1:0] btn_i,
   output logic [N_BTN-1:0] level_o,
   output logic             ev_valid_o,
   output logic [IDW-1:0]   ev_id_o,
   output logic             ev_rep_o,
   input  logic             ev_ready_i,
   output logic             ev_ovf_o,
   input  logic             ovf_clr_i
);

   localparam int unsigned PtrW = $clog2(QDEPTH);

   typedef struct packed {
      logic           rep;
      logic [IDW-1:0] id;
   } ev_entry_t;

   logic [N_BTN-1:0] rise;
   logic [N_BTN-1:0] rep_tick;

   for (genvar i = 0; i < N_BTN; i++) begin : g_cell
      button_event_arbiter_debounce_cell #(
         .DEB_CYCLES(DEB_CYCLES)
      ) u_cell (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .btn_i  (btn_i[i]),
         .level_o(level_o[i]),
         .rise_o (rise[i])
      );
   end

`ifdef BTN_REPEAT_EN
   logic [BtnCntW-1:0] rep_cnt_q [N_BTN];
   logic [BtnCntW-1:0] rep_cnt_d [N_BTN];
   logic [BtnCntW-1:0] rep_tgt_q [N_BTN];
   logic [BtnCntW-1:0] rep_tgt_d [N_BTN];

   // Hold counter is 0 in the first high cycle; the target steps by REP_PERIOD per tick.
   always_comb begin
      rep_tick = '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
         rep_cnt_d[i] = '0;
         rep_tgt_d[i] = BtnCntW'(REP_DELAY);
         if (level_o[i]) begin
            rep_cnt_d[i] = rep_cnt_q[i] + BtnCntW'(1);
            rep_tgt_d[i] = rep_tgt_q[i];
            if (rep_cnt_q[i] == rep_tgt_q[i]) begin
               rep_tick[i]  = 1'b1;
               rep_tgt_d[i] = rep_tgt_q[i] + BtnCntW'(REP_PERIOD);
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
         if (rst_i) begin
            rep_cnt_q[i] <= '0;
            rep_tgt_q[i] <= BtnCntW'(REP_DELAY);
         end else begin
            rep_cnt_q[i] <= rep_cnt_d[i];
            rep_tgt_q[i] <= rep_tgt_d[i];
         end
      end
   end
`else
   logic unused_rep_cfg;
   assign unused_rep_cfg = ^{REP_DELAY, REP_PERIOD};
   assign rep_tick       = '0;
`endif

   logic [N_BTN-1:0] pend_q, pend_d;
   logic [N_BTN-1:0] pend_rep_q, pend_rep_d;
   logic [IDW-1:0]   rr_q, rr_d;
   logic             ovf_q, ovf_d;

   ev_entry_t        mem_q [QDEPTH];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]    count_q, count_d;
   ev_entry_t        head;

   logic             push, pop, can_accept;
   logic [N_BTN-1:0] grant;
   logic             grant_any;
   logic [IDW-1:0]   grant_idx;
   logic [IDW:0]     pick;

   assign ev_valid_o = (count_q != '0);
   assign pop        = ev_valid_o & ev_ready_i;
   assign can_accept = (count_q != (PtrW+1)'(QDEPTH)) | pop;

   // Search starts just after the last grant and wraps.
   always_comb begin
      grant     = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      pick      = '0;
      for (int unsigned k = 1; k <= N_BTN; k++) begin
         pick = {1'b0, rr_q} + (IDW+1)'(k);
         if (pick >= (IDW+1)'(N_BTN)) begin
            pick = pick - (IDW+1)'(N_BTN);
         end
         if (can_accept && !grant_any && pend_q[pick[IDW-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = pick[IDW-1:0];
         end
      end
      if (grant_any) begin
         grant[grant_idx] = 1'b1;
      end
   end

   assign push = grant_any;
   assign rr_d = grant_any ? grant_idx : rr_q;

   always_comb begin
      pend_d     = pend_q & ~grant;
      pend_rep_d = pend_rep_q;
      ovf_d      = ovf_q & ~ovf_clr_i;
      for (int unsigned i = 0; i < N_BTN; i++) begin
         if (rise[i]) begin
            // A press whose predecessor is still waiting and not leaving now is lost.
            if (pend_q[i] && !grant[i]) begin
               ovf_d = 1'b1;
            end else begin
               pend_d[i]     = 1'b1;
               pend_rep_d[i] = 1'b0;
            end
         end else if (rep_tick[i] && (!pend_q[i] || grant[i])) begin
            pend_d[i]     = 1'b1;
            pend_rep_d[i] = 1'b1;
         end
      end
   end

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + (PtrW+1)'(1);
         2'b01:   count_d = count_q - (PtrW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pend_q     <= '0;
         pend_rep_q <= '0;
         rr_q       <= IDW'(N_BTN - 1);
         ovf_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         pend_q     <= pend_d;
         pend_rep_q <= pend_rep_d;
         rr_q       <= rr_d;
         ovf_q      <= ovf_d;
         count_q    <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{rep: pend_rep_q[grant_idx], id: grant_idx};
      end
   end

   assign head     = mem_q[rd_ptr_q];
   assign ev_id_o  = ev_valid_o ? head.id : '0;
   assign ev_rep_o = ev_valid_o & head.rep;
   assign ev_ovf_o = ovf_q;

endmodule
